// File: rtl/sec_encoder_pipe.sv
// rtl/sec_encoder_pipe.sv - (136,128) SEC Hamming encoder, 2-stage elastic pipeline
module sec_encoder_pipe #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_message,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [135:0]       out_codeword,
  input  logic               inj_arm,
  input  logic [135:0]       inj_mask,
  output logic               inj_busy,
  output logic [CNT_W-1:0]   word_count
);

  localparam logic [127:0] M7 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [127:0] M6 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
  localparam logic [127:0] M5 = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
  localparam logic [127:0] M4 = 128'hFF00_FF00_00FF_FF00_FF00_00FF_FF00_00FF;
  localparam logic [127:0] M3 = 128'hFF00_00FF_FF00_FF00_00FF_FF00_FF00_00FF;
  localparam logic [127:0] M2 = 128'h00FF_FF00_FF00_FF00_00FF_00FF_00FF_FF00;
  localparam logic [127:0] M1 = 128'h00FF_00FF_00FF_00FF_FF00_FF00_FF00_FF00;
  localparam logic [127:0] M0 = 128'h00FF_00FF_00FF_00FF_00FF_00FF_00FF_00FF;

  logic [7:0]   parity;
  logic         s1_valid;
  logic [127:0] s1_message;
  logic [7:0]   s1_parity;
  logic [135:0] inj_mask_q;
  logic         s2_adv;
  logic         s1_adv;
  logic         s1_to_s2;

  always_comb begin
    parity    = 8'h00;
    parity[7] = ^(in_message & M7);
    parity[6] = ^(in_message & M6);
    parity[5] = ^(in_message & M5);
    parity[4] = ^(in_message & M4);
    parity[3] = ^(in_message & M3);
    parity[2] = ^(in_message & M2);
    parity[1] = ^(in_message & M1);
    parity[0] = ^(in_message & M0);
  end

  // Each stage moves when it is empty or its successor is moving.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign s1_to_s2 = s1_valid && s2_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_message <= '0;
      s1_parity  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_message <= in_message;
        s1_parity  <= parity;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_codeword <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_codeword <= {s1_message, s1_parity} ^ (inj_busy ? inj_mask_q : 136'h0);
      end
    end
  end

  // An arm pulse coinciding with a transfer only latches for the following word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_busy   <= 1'b0;
      inj_mask_q <= '0;
    end else if (inj_busy) begin
      if (s1_to_s2) begin
        inj_busy <= 1'b0;
      end
    end else if (inj_arm) begin
      inj_busy   <= 1'b1;
      inj_mask_q <= inj_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (out_valid && out_ready) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sec_encoder_pipe.sv
// tb/tb_sec_encoder_pipe.sv - directed self-checking bench for sec_encoder_pipe
module tb_sec_encoder_pipe;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_message;
  logic         out_valid;
  logic         out_ready;
  logic [135:0] out_codeword;
  logic         inj_arm;
  logic [135:0] inj_mask;
  logic         inj_busy;
  logic [31:0]  word_count;

  int checks = 0;
  int errors = 0;

  sec_encoder_pipe #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_message   (in_message),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .inj_arm      (inj_arm),
    .inj_mask     (inj_mask),
    .inj_busy     (inj_busy),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_message = '0;
    out_ready = 1'b1;
    inj_arm = 1'b0;
    inj_mask = '0;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (out_codeword !== 136'h0) begin errors++; $display("FAIL reset_out_codeword got %h exp 0", out_codeword); end
    checks++;
    if (inj_busy !== 1'b0) begin errors++; $display("FAIL reset_inj_busy got %b exp 0", inj_busy); end
    checks++;
    if (word_count !== 32'd0) begin errors++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_zero_message;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_message = 128'h0;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_codeword !== 136'h0) begin
      errors++; $display("FAIL zero_codeword got v=%b %h exp v=1 0", out_valid, out_codeword);
    end
    tick;
    checks++;
    if (word_count !== 32'd1) begin errors++; $display("FAIL zero_word_count got %0d exp 1", word_count); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_drain got out_valid %b exp 0", out_valid); end
  endtask

  task automatic test_single_bits;
    logic [127:0] msgs [5];
    logic [7:0]   pars [5];
    msgs[0] = 128'h1;        pars[0] = 8'hF9;
    msgs[1] = 128'h1 << 127; pars[1] = 8'h18;
    msgs[2] = '1;            pars[2] = 8'h00;
    msgs[3] = 128'h2;        pars[3] = 8'h79;
    msgs[4] = 128'h100;      pars[4] = 8'hE6;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_message = msgs[i];
      tick;
      in_valid = 1'b0;
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_codeword !== {msgs[i], pars[i]}) begin
        errors++;
        $display("FAIL single_bit_%0d got v=%b %h exp v=1 %h", i, out_valid, out_codeword, {msgs[i], pars[i]});
      end
      tick;
    end
  endtask

  task automatic test_back_pressure;
    logic [127:0] msgs [3];
    logic [135:0] exp  [3];
    logic [31:0]  wc0;
    int sent;
    int got;
    msgs[0] = 128'h1;        exp[0] = {128'h1, 8'hF9};
    msgs[1] = 128'h1 << 127; exp[1] = {128'h1 << 127, 8'h18};
    msgs[2] = 128'h2;        exp[2] = {128'h2, 8'h79};
    wc0 = word_count;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 4);
      if (sent < 3) begin
        in_valid = 1'b1;
        in_message = msgs[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_cyc%0d got %b exp 0", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        if (got < 3) begin
          checks++;
          if (out_codeword !== exp[got]) begin
            errors++; $display("FAIL bp_order_%0d got %h exp %h", got, out_codeword, exp[got]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got); end
    checks++;
    if (word_count !== wc0 + 32'd3) begin errors++; $display("FAIL bp_word_count got %0d exp %0d", word_count, wc0 + 32'd3); end
  endtask

  task automatic test_inject;
    out_ready = 1'b1;
    inj_mask = 136'h100;
    inj_arm = 1'b1;
    tick;
    inj_arm = 1'b0;
    checks++;
    if (inj_busy !== 1'b1) begin errors++; $display("FAIL inj_busy_set got %b exp 1", inj_busy); end
    in_valid = 1'b1;
    in_message = 128'h0;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_codeword !== {128'h1, 8'h00}) begin
      errors++; $display("FAIL inj_codeword got v=%b %h exp v=1 %h", out_valid, out_codeword, {128'h1, 8'h00});
    end
    checks++;
    if (inj_busy !== 1'b0) begin errors++; $display("FAIL inj_busy_clear got %b exp 0", inj_busy); end
    tick;
    in_valid = 1'b1;
    in_message = 128'h0;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_codeword !== 136'h0) begin
      errors++; $display("FAIL inj_once got v=%b %h exp v=1 0", out_valid, out_codeword);
    end
    tick;
  endtask

  task automatic test_double_arm;
    out_ready = 1'b1;
    inj_mask = 136'h3;
    inj_arm = 1'b1;
    tick;
    inj_mask = 136'hF0;
    tick;
    inj_arm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_message = 128'h100;
      tick;
      in_valid = 1'b0;
      tick;
      checks++;
      if (out_codeword !== {128'h100, (i == 0) ? 8'hE5 : 8'hE6}) begin
        errors++; $display("FAIL double_arm_%0d got %h exp %h", i, out_codeword, {128'h100, (i == 0) ? 8'hE5 : 8'hE6});
      end
      tick;
    end
    checks++;
    if (inj_busy !== 1'b0) begin errors++; $display("FAIL double_arm_busy got %b exp 0", inj_busy); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_message = 128'h2;
    tick;
    in_message = 128'h100;
    tick;
    in_valid = 1'b0;
    inj_mask = 136'hFF;
    inj_arm = 1'b1;
    tick;
    inj_arm = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || inj_busy !== 1'b1) begin
      errors++; $display("FAIL mid_setup got v=%b busy=%b exp 1 1", out_valid, inj_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || inj_busy !== 1'b0) begin
      errors++; $display("FAIL mid_async got v=%b busy=%b exp 0 0", out_valid, inj_busy);
    end
    checks++;
    if (word_count !== 32'd0) begin errors++; $display("FAIL mid_word_count got %0d exp 0", word_count); end
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_message = 128'h1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_codeword !== {128'h1, 8'hF9}) begin
      errors++; $display("FAIL mid_first_word got v=%b %h exp v=1 %h", out_valid, out_codeword, {128'h1, 8'hF9});
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || word_count !== 32'd1) begin
      errors++; $display("FAIL mid_no_stale got v=%b wc=%0d exp v=0 wc=1", out_valid, word_count);
    end
  endtask

  initial begin
    test_reset;
    test_zero_message;
    test_single_bits;
    test_back_pressure;
    test_inject;
    test_double_arm;
    test_reset_midstream;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
